// File: rtl/ir_nec_pkg.sv
// NEC IR protocol constants and transmit state encoding, shared by the transmit and receive paths.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_GAP
  } nec_tx_state_t;

  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int REP_SPACE_U  = 4;
  localparam int BIT_MARK_U   = 1;
  localparam int ZERO_SPACE_U = 1;
  localparam int ONE_SPACE_U  = 3;
  localparam int STOP_U       = 1;

  // Unit counters count down to zero, so a segment of n units loads n-1.
  function automatic logic [15:0] units_m1(input int n);
    return 16'(n - 1);
  endfunction

endpackage

// File: rtl/ir_nec_tx_carrier.sv
// IR carrier generator: registered square wave, forced high on the cycle after a sync clear.
// Output is low whenever the enable is low, so it can drive the LED pin directly.
module ir_carrier_gen #(
  parameter int CARRIER_DIV = 1316
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic carrier
);

  localparam int W = (CARRIER_DIV > 2) ? $clog2(CARRIER_DIV) : 1;

  logic [W-1:0] cnt;
  logic [W-1:0] nxt;

  always_comb begin
    nxt = (cnt == W'(CARRIER_DIV - 1)) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      carrier <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      carrier <= 1'b1;
    end else if (en) begin
      cnt     <= nxt;
      carrier <= (nxt < W'(CARRIER_DIV / 2));
    end else begin
      carrier <= 1'b0;
    end
  end

endmodule

// File: rtl/ir_nec_tx.sv
// NEC IR transmitter: serialises a 32-bit word (LSB first) or a repeat code as a carrier-modulated waveform.
// One request at a time via valid/ready; tx_ready is high only while idle.
import ir_nec_pkg::*;

module ir_nec_tx #(
  parameter int UNIT_CYC    = 28125,
  parameter int CARRIER_DIV = 1316,
  parameter int GAP_UNITS   = 72
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [31:0] tx_data,
  input  logic        tx_repeat,
  output logic        ir_envelope,
  output logic        ir_out,
  output logic        busy,
  output logic        done
);

  localparam int CW = (UNIT_CYC > 2) ? $clog2(UNIT_CYC) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYC - 1);

  nec_tx_state_t state;
  logic [CW-1:0] cyc_cnt;
  logic [15:0]   unit_cnt;
  logic [5:0]    bit_idx;
  logic [31:0]   shreg;
  logic          cur_bit;
  logic          rep_q;

  logic seg_end, accept, mark_start, in_mark, car_en;

  // Carrier control is derived from the next state so the first mark cycle already carries a high phase.
  always_comb begin
    seg_end    = (cyc_cnt == CYC_LAST) && (unit_cnt == 16'd0);
    accept     = tx_valid && tx_ready;
    mark_start = accept || (seg_end && (state == S_LEAD_SPACE || state == S_BIT_SPACE));
    in_mark    = (state == S_LEAD_MARK) || (state == S_BIT_MARK) || (state == S_STOP_MARK);
    car_en     = mark_start || (in_mark && !seg_end);
  end

  ir_carrier_gen #(.CARRIER_DIV(CARRIER_DIV)) u_carrier (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (mark_start),
    .en      (car_en),
    .carrier (ir_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cyc_cnt     <= '0;
      unit_cnt    <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      cur_bit     <= 1'b0;
      rep_q       <= 1'b0;
      tx_ready    <= 1'b1;
      ir_envelope <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE) begin
        if (cyc_cnt == CYC_LAST) begin
          cyc_cnt <= '0;
          if (unit_cnt != 16'd0) unit_cnt <= unit_cnt - 16'd1;
        end else begin
          cyc_cnt <= cyc_cnt + 1'b1;
        end
      end
      case (state)
        S_IDLE: if (accept) begin
          state       <= S_LEAD_MARK;
          cyc_cnt     <= '0;
          unit_cnt    <= units_m1(LEAD_MARK_U);
          shreg       <= tx_data;
          rep_q       <= tx_repeat;
          tx_ready    <= 1'b0;
          busy        <= 1'b1;
          ir_envelope <= 1'b1;
        end
        S_LEAD_MARK: if (seg_end) begin
          state       <= S_LEAD_SPACE;
          unit_cnt    <= rep_q ? units_m1(REP_SPACE_U) : units_m1(LEAD_SPACE_U);
          ir_envelope <= 1'b0;
        end
        S_LEAD_SPACE: if (seg_end) begin
          ir_envelope <= 1'b1;
          bit_idx     <= '0;
          if (rep_q) begin
            state    <= S_STOP_MARK;
            unit_cnt <= units_m1(STOP_U);
          end else begin
            state    <= S_BIT_MARK;
            unit_cnt <= units_m1(BIT_MARK_U);
            cur_bit  <= shreg[0];
            shreg    <= shreg >> 1;
          end
        end
        S_BIT_MARK: if (seg_end) begin
          state       <= S_BIT_SPACE;
          unit_cnt    <= cur_bit ? units_m1(ONE_SPACE_U) : units_m1(ZERO_SPACE_U);
          ir_envelope <= 1'b0;
        end
        S_BIT_SPACE: if (seg_end) begin
          ir_envelope <= 1'b1;
          if (bit_idx == 6'd31) begin
            state    <= S_STOP_MARK;
            unit_cnt <= units_m1(STOP_U);
          end else begin
            state    <= S_BIT_MARK;
            unit_cnt <= units_m1(BIT_MARK_U);
            bit_idx  <= bit_idx + 6'd1;
            cur_bit  <= shreg[0];
            shreg    <= shreg >> 1;
          end
        end
        S_STOP_MARK: if (seg_end) begin
          ir_envelope <= 1'b0;
          if (GAP_UNITS == 0) begin
            state    <= S_IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            state    <= S_GAP;
            unit_cnt <= units_m1(GAP_UNITS);
          end
        end
        S_GAP: if (seg_end) begin
          state    <= S_IDLE;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_nec_tx.sv
// Directed bench for ir_nec_tx with short units: envelope run lengths, carrier phase, loopback decode, handshake and reset.
module tb_ir_nec_tx;

  localparam int UNIT = 4;
  localparam int DIV  = 2;
  localparam int GAPU = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        tx_repeat;
  logic        ir_envelope;
  logic        ir_out;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  ir_nec_tx #(.UNIT_CYC(UNIT), .CARRIER_DIV(DIV), .GAP_UNITS(GAPU)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_repeat   (tx_repeat),
    .ir_envelope (ir_envelope),
    .ir_out      (ir_out),
    .busy        (busy),
    .done        (done)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int runs[$];
  int expq[$];
  int done_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // Wait for ready, present a request, and change the inputs right after the accept edge.
  task automatic start(input logic [31:0] d, input logic rep, input logic hold_v,
                       input logic [31:0] d_after, input logic rep_after);
    int w = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", tx_ready, 1);
    tx_valid  = 1'b1;
    tx_data   = d;
    tx_repeat = rep;
    @(posedge clk);
    #1;
    check("accept_busy", busy, 1);
    check("accept_env", ir_envelope, 1);
    tx_data   = d_after;
    tx_repeat = rep_after;
    tx_valid  = hold_v;
  endtask

  // Record signed envelope run lengths (+high/-low) until done; check carrier phase and status flags on the way.
  task automatic capture();
    int   len = 0;
    int   cyc = 0;
    int   carrier_err = 0;
    int   busy_err = 0;
    int   ready_err = 0;
    logic lvl = 1'b1;
    logic want_ir;
    runs.delete();
    done_cyc = -1;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (ir_envelope !== lvl) begin
        runs.push_back(lvl ? len : -len);
        lvl = ir_envelope;
        len = 0;
      end
      want_ir = lvl ? ((len % DIV) < DIV / 2) : 1'b0;
      if (ir_out !== want_ir) carrier_err++;
      if (busy !== 1'b1) busy_err++;
      if (tx_ready !== 1'b0) ready_err++;
      len++;
    end
    runs.push_back(lvl ? len : -len);
    check("done_seen", (done_cyc > 0), 1);
    check("done_ready", tx_ready, 1);
    check("done_busy", busy, 0);
    check("done_env", ir_envelope, 0);
    check("carrier_errs", carrier_err, 0);
    check("busy_errs", busy_err, 0);
    check("ready_errs", ready_err, 0);
  endtask

  task automatic build_exp(input logic [31:0] d, input logic rep);
    expq.delete();
    expq.push_back(16 * UNIT);
    expq.push_back(rep ? -4 * UNIT : -8 * UNIT);
    if (!rep) begin
      for (int i = 0; i < 32; i++) begin
        expq.push_back(UNIT);
        expq.push_back(d[i] ? -3 * UNIT : -UNIT);
      end
    end
    expq.push_back(UNIT);
    expq.push_back(-GAPU * UNIT);
  endtask

  task automatic compare(input string tag, input int total);
    check({tag, "_nruns"}, runs.size(), expq.size());
    for (int i = 0; i < expq.size() && i < runs.size(); i++)
      check($sformatf("%s_run%0d", tag, i), runs[i], expq[i]);
    check({tag, "_done_cyc"}, done_cyc, total);
  endtask

  // Receiver-side view: a space longer than two units is a one.
  function automatic logic [31:0] decode();
    logic [31:0] w = '0;
    if (runs.size() < 67) return 'x;
    for (int i = 0; i < 32; i++) w[i] = (-runs[3 + 2 * i]) > 2 * UNIT;
    return w;
  endfunction

  initial begin
    int bad;
    rst_n     = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_repeat = 1'b0;
    #12;
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_env", ir_envelope, 0);
    check("rst_irout", ir_out, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero word: 89 units + 2 gap units, done on the following cycle.
    start(32'h0000_0000, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    capture();
    build_exp(32'h0000_0000, 1'b0);
    compare("zero", 365);
    check("zero_decode", decode(), 32'h0000_0000);
    @(negedge clk);
    check("zero_done_pulse", done, 0);

    // All-ones word: 612 cycles of mark/space.
    start(32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b1);
    capture();
    build_exp(32'hFFFF_FFFF, 1'b0);
    compare("ones", 621);
    check("ones_decode", decode(), 32'hFFFF_FFFF);
    @(negedge clk);
    check("ones_done_pulse", done, 0);

    // Repeat code: data is ignored.
    start(32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b0);
    capture();
    build_exp(32'h0, 1'b1);
    compare("rep", 93);
    @(negedge clk);
    check("rep_done_pulse", done, 0);

    // Valid held across a frame, second word re-accepted on the done edge.
    start(32'hE11E_00FF, 1'b0, 1'b1, 32'h0000_0001, 1'b0);
    capture();
    build_exp(32'hE11E_00FF, 1'b0);
    compare("mix", 493);
    check("mix_decode", decode(), 32'hE11E_00FF);
    @(posedge clk);
    #1;
    check("b2b_busy", busy, 1);
    check("b2b_env", ir_envelope, 1);
    check("b2b_irout", ir_out, 1);
    check("b2b_ready", tx_ready, 0);
    tx_valid = 1'b0;
    capture();
    build_exp(32'h0000_0001, 1'b0);
    compare("b2b", 373);
    check("b2b_decode", decode(), 32'h0000_0001);

    // Reset during the first bit space aborts the frame.
    start(32'h0000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (102) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_env", ir_envelope, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_irout", ir_out, 0);
    check("mid_rst_env", ir_envelope, 0);
    check("mid_rst_ready", tx_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || ir_envelope !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) bad++;
    end
    check("post_rst_quiet", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
